// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding, sequencer state type and widths
package alu_pkg;

    localparam int OP_W    = 3;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = OP_W + DATA_W;

    typedef enum logic [OP_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_e;

    // Only these opcodes load the ALU result back into the accumulator.
    function automatic logic writes_acc(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational accumulator ALU driven by the sequencer
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] accum,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero
);

    // Result selection; non-writing opcodes pass the accumulator through.
    always_comb begin
        alu_out = accum;
        case (alu_op_e'(opcode))
            OP_ADD:  alu_out = accum + data;
            OP_AND:  alu_out = accum & data;
            OP_XOR:  alu_out = accum ^ data;
            OP_LDA:  alu_out = data;
            default: alu_out = accum;
        endcase
    end

    assign zero = (accum == '0);

endmodule

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - instruction buffer, power-of-two depth, show-ahead read
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; reset empties the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - buffered instruction sequencer driving an external accumulator ALU
module alu_seq
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [DATA_W-1:0] instr_data,
    input  logic              resume,
    output logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] accum,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              zero,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_acc,
    output logic              halted
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_e        state_q, state_d;
    alu_op_e           op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] res_acc_q, res_acc_d;
    logic              res_valid_q, res_valid_d;
    logic              skip_q, skip_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [INSTR_W-1:0] fifo_rdata;
    logic               fetch, skip_now;

    assign fifo_push   = instr_valid && instr_ready;
    assign instr_ready = reset && (!fifo_full || fifo_pop);

    seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({instr_op, instr_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic; WB fetches directly so back-to-back issue needs no IDLE cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        acc_d       = acc_q;
        res_acc_d   = res_acc_q;
        res_valid_d = 1'b0;
        skip_d      = skip_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;
        fetch       = 1'b0;
        skip_now    = skip_q;

        case (state_q)
            ST_IDLE: begin
                fetch = 1'b1;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = (ALU_LAT == 1) ? ST_WB : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ALU_LAT - 2)) state_d = ST_WB;
            end
            ST_WB: begin
                res_valid_d = 1'b1;
                if (writes_acc(op_q)) acc_d = alu_out;
                res_acc_d = acc_d;
                if (op_q == OP_HLT) begin
                    state_d = ST_HALTED;
                end else begin
                    fetch    = 1'b1;
                    skip_now = (op_q == OP_SKZ) && zero;
                end
            end
            ST_HALTED: begin
                if (resume) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A pending skip consumes exactly one popped instruction without issuing it.
        if (fetch) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (skip_now) begin
                    skip_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    op_d    = alu_op_e'(fifo_rdata[INSTR_W-1:DATA_W]);
                    data_d  = fifo_rdata[DATA_W-1:0];
                    state_d = ST_ISSUE;
                end
            end else begin
                skip_d  = skip_now;
                state_d = ST_IDLE;
            end
        end
    end

    // Sequencer state; reset drops everything in flight immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_HLT;
            data_q      <= '0;
            acc_q       <= '0;
            res_acc_q   <= '0;
            res_valid_q <= 1'b0;
            skip_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            acc_q       <= acc_d;
            res_acc_q   <= res_acc_d;
            res_valid_q <= res_valid_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
        end
    end

    assign opcode    = op_q;
    assign data      = data_q;
    assign accum     = acc_q;
    assign res_acc   = res_acc_q;
    assign res_valid = res_valid_q;
    assign halted    = (state_q == ST_HALTED);

endmodule
